// File: rtl/n64a_gamma_lut_module_pkg.sv
// -----------------------------------------------------------------------------
// n64a_gamma_lut_module_pkg
//   Shared definitions for the run-time loadable gamma LUT stage:
//   - default geometry (channels, colour widths, sync width)
//   - load FSM state encoding
//   - LUT depth helper
//   Optional feature macro used by the design: N64A_GAMMA_LUT_READBACK_EN
// -----------------------------------------------------------------------------
package n64a_gamma_lut_module_pkg;

  localparam int NUM_CH_DEF    = 3;
  localparam int COLOR_W_I_DEF = 7;
  localparam int COLOR_W_O_DEF = 8;
  localparam int SYNC_W_DEF    = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } load_state_e;

  // One LUT entry per possible input colour code.
  function automatic int lut_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/n64a_gamma_lut_module_if.sv
// -----------------------------------------------------------------------------
// n64a_gamma_lut_module_if
//   LUT load stream between the controller (master) and the gamma stage (slave).
//   Signals:
//     lut_load_start_i  master->slave  pulse, (re)start load at address 0
//     lut_wr_valid_i    master->slave  write word valid
//     lut_wr_data_i     master->slave  LUT entry, broadcast to all channels
//     lut_wr_ready_o    slave->master  word accepted (high exactly while loading)
// -----------------------------------------------------------------------------
interface n64a_gamma_lut_module_if
  import n64a_gamma_lut_module_pkg::*;
#(
  parameter int DW = COLOR_W_O_DEF
);
  logic          lut_load_start_i;
  logic          lut_wr_valid_i;
  logic [DW-1:0] lut_wr_data_i;
  logic          lut_wr_ready_o;

  modport master (
    output lut_load_start_i,
    output lut_wr_valid_i,
    output lut_wr_data_i,
    input  lut_wr_ready_o
  );

  modport slave (
    input  lut_load_start_i,
    input  lut_wr_valid_i,
    input  lut_wr_data_i,
    output lut_wr_ready_o
  );
endinterface

// File: rtl/n64a_gamma_lut_ram.sv
// -----------------------------------------------------------------------------
// n64a_gamma_lut_ram
//   Simple dual-port RAM, one write port and one registered read port
//   (read-during-write to the same address returns the old word).
//   An optional second registered read port (RD2_EN) with reset-to-zero
//   output serves the LUT readback path.
//   Ports:
//     clk_i, rst_ni            clock, async active-low reset (read port 2 only)
//     we_i/waddr_i/wdata_i     write port
//     re_i/raddr_i/rdata_o     read port 1, output updates only when re_i
//     rd2_addr_i/rd2_data_o    read port 2 (tied to 0 when RD2_EN = 0)
// -----------------------------------------------------------------------------
module n64a_gamma_lut_ram
  import n64a_gamma_lut_module_pkg::*;
#(
  parameter int AW     = 7,
  parameter int DW     = 8,
  parameter bit RD2_EN = 1'b0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o,
  input  logic [AW-1:0] rd2_addr_i,
  output logic [DW-1:0] rd2_data_o
);
  localparam int DEPTH = lut_depth(AW);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // No reset on the array or the main read register so the RAM maps to block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

  if (RD2_EN) begin : g_rd2
    logic [DW-1:0] rd2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rd2_q <= '0;
      end else begin
        rd2_q <= mem_q[rd2_addr_i];
      end
    end

    assign rd2_data_o = rd2_q;
  end else begin : g_no_rd2
    logic unused_rd2;
    assign unused_rd2 = ^{rst_ni, rd2_addr_i};
    assign rd2_data_o = '0;
  end

endmodule

// File: rtl/n64a_gamma_lut_module.sv
// -----------------------------------------------------------------------------
// n64a_gamma_lut_module
//   Run-time loadable gamma correction. Each colour channel is mapped through
//   its own copy of a RAM LUT; the controller loads the (shared) table through
//   a valid/ready stream. The pixel pipeline advances only on nDSYNC-low
//   strobes and has a latency of two strobes.
//   Ports:
//     VCLK, nRST        video clock, async active-low reset
//     nDSYNC            pixel strobe, active low, pipeline enable
//     gamma_en_i        1 = apply LUT, 0 = bypass (MSB-replicated widening)
//     lut_if (slave)    LUT load stream (start / valid / data / ready)
//     lut_valid_o       complete table present
//     video_data_i      {sync, ch[NUM_CH-1..0]}, COLOR_W_I bits per channel
//     video_data_o      {sync, ch[NUM_CH-1..0]}, COLOR_W_O bits per channel
//   Optional (macro N64A_GAMMA_LUT_READBACK_EN):
//     lut_rd_addr_i / lut_rd_data_o  read channel-0 table copy, 1-cycle latency
// -----------------------------------------------------------------------------
module n64a_gamma_lut_module
  import n64a_gamma_lut_module_pkg::*;
#(
  parameter int NUM_CH    = NUM_CH_DEF,
  parameter int COLOR_W_I = COLOR_W_I_DEF,
  parameter int COLOR_W_O = COLOR_W_O_DEF,
  parameter int SYNC_W    = SYNC_W_DEF
) (
  input  logic                              VCLK,
  input  logic                              nRST,
  input  logic                              nDSYNC,
  input  logic                              gamma_en_i,
  n64a_gamma_lut_module_if.slave            lut_if,
  output logic                              lut_valid_o,
  input  logic [SYNC_W+NUM_CH*COLOR_W_I-1:0] video_data_i,
  output logic [SYNC_W+NUM_CH*COLOR_W_O-1:0] video_data_o
`ifdef N64A_GAMMA_LUT_READBACK_EN
  ,
  input  logic [COLOR_W_I-1:0]              lut_rd_addr_i,
  output logic [COLOR_W_O-1:0]              lut_rd_data_o
`endif
);

  localparam int                   DEPTH     = lut_depth(COLOR_W_I);
  localparam logic [COLOR_W_I-1:0] LAST_ADDR = COLOR_W_I'(DEPTH - 1);
  localparam int                   VI_W      = SYNC_W + NUM_CH * COLOR_W_I;
  localparam int                   VO_W      = SYNC_W + NUM_CH * COLOR_W_O;

`ifdef N64A_GAMMA_LUT_READBACK_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Load FSM. A start pulse always wins: it restarts at address 0 and drops
  // any word offered in the same cycle.
  // ---------------------------------------------------------------------------
  load_state_e          state_q;
  logic [COLOR_W_I-1:0] wr_addr_q;
  logic                 ready_q;
  logic                 lut_valid_q;
  logic                 wr_en;

  assign wr_en = ready_q & lut_if.lut_wr_valid_i & ~lut_if.lut_load_start_i;

  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= ST_IDLE;
      wr_addr_q   <= '0;
      ready_q     <= 1'b0;
      lut_valid_q <= 1'b0;
    end else if (lut_if.lut_load_start_i) begin
      state_q     <= ST_LOAD;
      wr_addr_q   <= '0;
      ready_q     <= 1'b1;
      lut_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (lut_if.lut_wr_valid_i) begin
            if (wr_addr_q == LAST_ADDR) begin
              // Address parks at the last entry; no wrap into a second pass.
              state_q     <= ST_IDLE;
              ready_q     <= 1'b0;
              lut_valid_q <= 1'b1;
            end else begin
              wr_addr_q <= wr_addr_q + COLOR_W_I'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign lut_if.lut_wr_ready_o = ready_q;
  assign lut_valid_o           = lut_valid_q;

  // ---------------------------------------------------------------------------
  // Pixel pipeline
  // ---------------------------------------------------------------------------
  logic                        pix_en;
  logic                        sel_d;
  logic                        sel_q;
  logic [SYNC_W-1:0]           sync_q;
  logic [NUM_CH*COLOR_W_O-1:0] bypass_d;
  logic [NUM_CH*COLOR_W_O-1:0] bypass_q;
  logic [NUM_CH*COLOR_W_O-1:0] lut_rd;
  logic [NUM_CH*COLOR_W_O-1:0] rb_data;
  logic [COLOR_W_I-1:0]        rb_addr;
  logic [VO_W-1:0]             video_d;
  logic [VO_W-1:0]             video_q;

  assign pix_en = ~nDSYNC;
  // Never select the table while it is being rewritten, to avoid torn output.
  assign sel_d  = gamma_en_i & lut_valid_q & ~ready_q;

`ifdef N64A_GAMMA_LUT_READBACK_EN
  assign rb_addr       = lut_rd_addr_i;
  assign lut_rd_data_o = rb_data[COLOR_W_O-1:0];
`else
  assign rb_addr = '0;
`endif

  logic unused_rb;
  assign unused_rb = ^rb_data;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [COLOR_W_I-1:0] c;
      assign c = video_data_i[gi*COLOR_W_I +: COLOR_W_I];

      // Widen by replicating MSBs into the new LSBs so 0 -> 0 and max -> max.
      if (COLOR_W_O > COLOR_W_I) begin : g_widen
        assign bypass_d[gi*COLOR_W_O +: COLOR_W_O] =
          {c, c[COLOR_W_I-1 -: COLOR_W_O-COLOR_W_I]};
      end else begin : g_same
        assign bypass_d[gi*COLOR_W_O +: COLOR_W_O] = c;
      end

      n64a_gamma_lut_ram #(
        .AW     (COLOR_W_I),
        .DW     (COLOR_W_O),
        .RD2_EN (RB_EN && (gi == 0))
      ) u_ram (
        .clk_i      (VCLK),
        .rst_ni     (nRST),
        .we_i       (wr_en),
        .waddr_i    (wr_addr_q),
        .wdata_i    (lut_if.lut_wr_data_i),
        .re_i       (pix_en),
        .raddr_i    (c),
        .rdata_o    (lut_rd[gi*COLOR_W_O +: COLOR_W_O]),
        .rd2_addr_i (rb_addr),
        .rd2_data_o (rb_data[gi*COLOR_W_O +: COLOR_W_O])
      );
    end
  endgenerate

  assign video_d = {sync_q, sel_q ? lut_rd : bypass_q};

  // Stage 1 runs alongside the RAM read register; stage 2 is the output.
  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      sel_q    <= 1'b0;
      sync_q   <= '0;
      bypass_q <= '0;
      video_q  <= '0;
    end else if (pix_en) begin
      sel_q    <= sel_d;
      sync_q   <= video_data_i[VI_W-1 -: SYNC_W];
      bypass_q <= bypass_d;
      video_q  <= video_d;
    end
  end

  assign video_data_o = video_q;

endmodule

// File: tb/tb_n64a_gamma_lut_module.sv
// -----------------------------------------------------------------------------
// tb_n64a_gamma_lut_module
//   Directed sequence with randomized data against a reference model of the
//   gamma stage (table contents, load progress, two-strobe pixel delay).
// -----------------------------------------------------------------------------
module tb_n64a_gamma_lut_module;
  localparam int NCH   = 3;
  localparam int WI    = 7;
  localparam int WO    = 8;
  localparam int SW    = 4;
  localparam int DEPTH = 1 << WI;
  localparam int VIW   = SW + NCH * WI;
  localparam int VOW   = SW + NCH * WO;

  logic           VCLK = 1'b0;
  logic           nRST = 1'b0;
  logic           nDSYNC = 1'b1;
  logic           gamma_en_i = 1'b0;
  logic           lut_valid_o;
  logic [VIW-1:0] video_data_i = '0;
  logic [VOW-1:0] video_data_o;
`ifdef N64A_GAMMA_LUT_READBACK_EN
  logic [WI-1:0]  lut_rd_addr_i = '0;
  logic [WO-1:0]  lut_rd_data_o;
`endif

  n64a_gamma_lut_module_if #(.DW(WO)) lut_if ();

  always #5 VCLK = ~VCLK;

  n64a_gamma_lut_module dut (
    .VCLK         (VCLK),
    .nRST         (nRST),
    .nDSYNC       (nDSYNC),
    .gamma_en_i   (gamma_en_i),
    .lut_if       (lut_if),
    .lut_valid_o  (lut_valid_o),
    .video_data_i (video_data_i),
    .video_data_o (video_data_o)
`ifdef N64A_GAMMA_LUT_READBACK_EN
    ,
    .lut_rd_addr_i(lut_rd_addr_i),
    .lut_rd_data_o(lut_rd_data_o)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int             m_lut [DEPTH];
  bit             m_loading;
  bit             m_valid;
  int             m_addr;
  logic [VOW-1:0] m_pipe [$];
  logic [WO-1:0]  m_rb;

  task automatic check(input string tag, input logic [VOW-1:0] obs, input logic [VOW-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [VOW-1:0] ref_pixel(input logic [VIW-1:0] vin, input bit use_lut);
    logic [VOW-1:0] r;
    int c;
    int o;
    r = '0;
    r[VOW-1 -: SW] = vin[VIW-1 -: SW];
    for (int k = 0; k < NCH; k++) begin
      c = int'(vin[k*WI +: WI]);
      if (use_lut) o = m_lut[c];
      else         o = (c << (WO - WI)) | (c >> (2 * WI - WO));
      r[k*WO +: WO] = o[WO-1:0];
    end
    return r;
  endfunction

  task automatic model_reset();
    m_loading = 1'b0;
    m_valid   = 1'b0;
    m_addr    = 0;
    m_rb      = '0;
    m_pipe    = {};
    m_pipe.push_back('0);
    m_pipe.push_back('0);
  endtask

  // One clock: update the model from the inputs seen at this edge, then check.
  task automatic step();
    logic [VOW-1:0] pix;
    if (!nDSYNC) begin
      pix = ref_pixel(video_data_i, gamma_en_i && m_valid && !m_loading);
      m_pipe.push_back(pix);
      void'(m_pipe.pop_front());
    end
`ifdef N64A_GAMMA_LUT_READBACK_EN
    m_rb = WO'(m_lut[lut_rd_addr_i]);
`endif
    if (lut_if.lut_load_start_i) begin
      m_loading = 1'b1;
      m_addr    = 0;
      m_valid   = 1'b0;
    end else if (m_loading && lut_if.lut_wr_valid_i) begin
      m_lut[m_addr] = int'(lut_if.lut_wr_data_i);
      if (m_addr == DEPTH - 1) begin
        m_loading = 1'b0;
        m_valid   = 1'b1;
      end else begin
        m_addr++;
      end
    end
    @(posedge VCLK);
    #1;
    check("video", video_data_o, m_pipe[0]);
    check("ready", VOW'(lut_if.lut_wr_ready_o), VOW'(m_loading));
    check("lut_valid", VOW'(lut_valid_o), VOW'(m_valid));
`ifdef N64A_GAMMA_LUT_READBACK_EN
    check("readback", VOW'(lut_rd_data_o), VOW'(m_rb));
`endif
  endtask

  task automatic start_load();
    lut_if.lut_load_start_i = 1'b1;
    lut_if.lut_wr_valid_i   = 1'b0;
    step();
    lut_if.lut_load_start_i = 1'b0;
  endtask

  // Offer n accepted words (random gaps, random pixel traffic meanwhile).
  // ramp=1: entry i = 255 - 2*i, otherwise random entries.
  task automatic write_words(input bit ramp, input int first, input int n);
    int i;
    i = 0;
    while (i < n) begin
      lut_if.lut_wr_valid_i = ($urandom_range(0, 3) != 0);
      lut_if.lut_wr_data_i  = ramp ? WO'(255 - 2 * (first + i)) : WO'($urandom);
      nDSYNC       = $urandom_range(0, 1);
      video_data_i = VIW'($urandom);
      gamma_en_i   = $urandom_range(0, 1);
      step();
      if (lut_if.lut_wr_valid_i) i++;
    end
    lut_if.lut_wr_valid_i = 1'b0;
  endtask

  task automatic random_pixels(input int n, input bit sparse);
    for (int k = 0; k < n; k++) begin
      nDSYNC       = sparse ? (k % 4 != 0) : 1'(($urandom_range(0, 3) == 0));
      video_data_i = VIW'($urandom);
      gamma_en_i   = ($urandom_range(0, 4) != 0);
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_lut[i] = 0;
    model_reset();
    lut_if.lut_load_start_i = 1'b0;
    lut_if.lut_wr_valid_i   = 1'b0;
    lut_if.lut_wr_data_i    = '0;

    // Reset state
    repeat (2) @(posedge VCLK);
    #1;
    check("rst_video", video_data_o, '0);
    check("rst_ready", VOW'(lut_if.lut_wr_ready_o), '0);
    check("rst_valid", VOW'(lut_valid_o), '0);
    nRST = 1'b1;

    // No table: gamma_en_i=1 still bypasses; 7'h40 widens to 8'h81
    gamma_en_i   = 1'b1;
    nDSYNC       = 1'b0;
    video_data_i = {4'hA, 7'h40, 7'h40, 7'h40};
    step();
    step();
    check("bypass_40", VOW'(video_data_o[WO-1:0]), VOW'(8'h81));
    nDSYNC = 1'b1;

    // Word offered while idle is ignored
    lut_if.lut_wr_valid_i = 1'b1;
    lut_if.lut_wr_data_i  = 8'h33;
    step();
    lut_if.lut_wr_valid_i = 1'b0;

    // Ramp table load
    start_load();
    write_words(1'b1, 0, DEPTH);
    check("ramp_valid", VOW'(lut_valid_o), VOW'(1'b1));

    // Ramp endpoints through the table
    gamma_en_i   = 1'b1;
    nDSYNC       = 1'b0;
    video_data_i = {4'h3, 7'h00, 7'h7F, 7'h00};
    step();
    step();
    check("ramp_ch0", VOW'(video_data_o[WO-1:0]), VOW'(8'hFF));
    check("ramp_ch1", VOW'(video_data_o[2*WO-1:WO]), VOW'(8'h01));
    nDSYNC = 1'b1;

`ifdef N64A_GAMMA_LUT_READBACK_EN
    lut_rd_addr_i = 7'd10;
    step();
    check("readback_10", VOW'(lut_rd_data_o), VOW'(8'hEB));
`endif

    // Strobe every 4th cycle; outputs must hold between strobes
    random_pixels(40, 1'b1);
    random_pixels(30, 1'b0);

    // Restart at address 50 with a concurrent word: word dropped
    start_load();
    write_words(1'b0, 0, 50);
    lut_if.lut_load_start_i = 1'b1;
    lut_if.lut_wr_valid_i   = 1'b1;
    lut_if.lut_wr_data_i    = 8'h5A;
    step();
    lut_if.lut_load_start_i = 1'b0;
    write_words(1'b0, 0, DEPTH - 1);
    check("restart_not_valid", VOW'(lut_valid_o), '0);
    write_words(1'b0, 0, 1);
    random_pixels(40, 1'b0);

    // Reset in the middle of a load
    start_load();
    write_words(1'b1, 0, 30);
    nRST = 1'b0;
    #2;
    check("midrst_video", video_data_o, '0);
    check("midrst_ready", VOW'(lut_if.lut_wr_ready_o), '0);
    check("midrst_valid", VOW'(lut_valid_o), '0);
    model_reset();
    @(posedge VCLK);
    #1;
    nRST = 1'b1;
    start_load();
    write_words(1'b1, 0, DEPTH);
    random_pixels(40, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
